// File: rtl/rv_instr_encoder.sv
// RV32I instruction encoder: field-level requests in, legal 32-bit words out
// through a small FIFO. Define RV_ENC_PARITY_EN to add a per-word parity output.
module rv_instr_encoder #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       inst_type,
    input  logic [3:0]       alu_ctrl,
    input  logic             shamt_en,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [31:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      instruction_word,
    output logic             err_illegal,
    input  logic             err_clr,
`ifdef RV_ENC_PARITY_EN
    output logic             out_parity,
`endif
    output logic [CNT_W-1:0] enc_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    localparam logic [2:0] T_R     = 3'd0;
    localparam logic [2:0] T_IALU  = 3'd1;
    localparam logic [2:0] T_LOAD  = 3'd2;
    localparam logic [2:0] T_STORE = 3'd3;
    localparam logic [2:0] T_LUI   = 3'd4;

    logic [31:0]      mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      occ_q, occ_d;
    logic             in_ready_q;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [2:0]  funct3;
    logic        f7b;
    logic        illegal;
    logic [31:0] enc_word;
    logic        accept, push, pop;

    assign funct3 = alu_ctrl[2:0];
    assign f7b    = alu_ctrl[3];

    always_comb begin
        illegal = 1'b0;
        if (inst_type > T_LUI)
            illegal = 1'b1;
        if (shamt_en && inst_type != T_IALU)
            illegal = 1'b1;
        if (inst_type == T_R && f7b && funct3 != 3'b000 && funct3 != 3'b101)
            illegal = 1'b1;
        if (inst_type == T_IALU) begin
            if (shamt_en != (funct3 == 3'b001 || funct3 == 3'b101))
                illegal = 1'b1;
            if (f7b && funct3 != 3'b101)
                illegal = 1'b1;
        end
        if (inst_type == T_LOAD &&
            (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111))
            illegal = 1'b1;
        if (inst_type == T_STORE && funct3 > 3'b010)
            illegal = 1'b1;
    end

    always_comb begin
        enc_word = 32'd0;
        case (inst_type)
            T_R:     enc_word = {1'b0, f7b, 5'b0, rs2, rs1, funct3, rd, 7'b0110011};
            T_IALU:  enc_word = shamt_en
                              ? {1'b0, f7b, 5'b0, imm[4:0], rs1, funct3, rd, 7'b0010011}
                              : {imm[11:0], rs1, funct3, rd, 7'b0010011};
            T_LOAD:  enc_word = {imm[11:0], rs1, funct3, rd, 7'b0000011};
            T_STORE: enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011};
            T_LUI:   enc_word = {imm[31:12], rd, 7'b0110111};
            default: enc_word = 32'd0;
        endcase
    end

    assign accept    = in_valid && in_ready_q;
    assign push      = accept && !illegal;
    assign out_valid = (occ_q != '0);
    assign pop       = out_valid && out_ready;

    always_comb begin
        occ_d = occ_q;
        if (push && !pop)
            occ_d = occ_q + 1'b1;
        else if (pop && !push)
            occ_d = occ_q - 1'b1;
    end

    // An illegal acceptance beats a simultaneous clear.
    always_comb begin
        err_d = err_q;
        if (accept && illegal)
            err_d = 1'b1;
        else if (err_clr)
            err_d = 1'b0;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (push && cnt_q != '1)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            in_ready_q <= 1'b1;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= 32'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= enc_word;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            occ_q      <= occ_d;
            in_ready_q <= (occ_d < DEPTH_L);
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

`ifdef RV_ENC_PARITY_EN
    logic par_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                par_q[i] <= 1'b0;
        end else if (push) begin
            par_q[wr_ptr_q] <= ^enc_word;
        end
    end

    assign out_parity = par_q[rd_ptr_q];
`endif

    assign in_ready         = in_ready_q;
    assign instruction_word = mem_q[rd_ptr_q];
    assign err_illegal      = err_q;
    assign enc_count        = cnt_q;
endmodule

// File: tb/tb_rv_instr_encoder.sv
// Directed self-checking bench for rv_instr_encoder (default DEPTH=2, CNT_W=16).
module tb_rv_instr_encoder;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  inst_type;
    logic [3:0]  alu_ctrl;
    logic        shamt_en;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instruction_word;
    logic        err_illegal;
    logic        err_clr;
    logic [15:0] enc_count;
`ifdef RV_ENC_PARITY_EN
    logic        out_parity;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] W_ADD   = 32'h004A82B3;
    localparam logic [31:0] W_SUB   = 32'h405A8333;
    localparam logic [31:0] W_LUI   = 32'h0F56B6B7;
    localparam logic [31:0] W_STORE = 32'h0F56A6A3;
    localparam logic [31:0] W_SRAI  = 32'h40315093;

    always #5 clk = ~clk;

    rv_instr_encoder dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .inst_type        (inst_type),
        .alu_ctrl         (alu_ctrl),
        .shamt_en         (shamt_en),
        .rd               (rd),
        .rs1              (rs1),
        .rs2              (rs2),
        .imm              (imm),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .instruction_word (instruction_word),
        .err_illegal      (err_illegal),
        .err_clr          (err_clr),
`ifdef RV_ENC_PARITY_EN
        .out_parity       (out_parity),
`endif
        .enc_count        (enc_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [2:0] t, input logic [3:0] ac, input logic se,
                       input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [31:0] im);
        in_valid  = 1'b1;
        inst_type = t;
        alu_ctrl  = ac;
        shamt_en  = se;
        rd        = d;
        rs1       = s1;
        rs2       = s2;
        imm       = im;
    endtask

    task automatic req_add();  req(3'd0, 4'b0000, 1'b0, 5'd5,  5'd21, 5'd4,  32'h0);        endtask
    task automatic req_sub();  req(3'd0, 4'b1000, 1'b0, 5'd6,  5'd21, 5'd5,  32'h0);        endtask
    task automatic req_lui();  req(3'd4, 4'b0000, 1'b0, 5'd13, 5'd0,  5'd0,  32'h0F56B000); endtask
    task automatic req_bad();  req(3'd2, 4'b0011, 1'b0, 5'd1,  5'd2,  5'd0,  32'h0);        endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; inst_type = 3'd0; alu_ctrl = 4'd0; shamt_en = 1'b0;
        rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; imm = 32'd0; out_ready = 1'b1; err_clr = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready",  32'(in_ready),    32'd1);
        chk("rst_out_valid", 32'(out_valid),   32'd0);
        chk("rst_word",      instruction_word, 32'd0);
        chk("rst_err",       32'(err_illegal), 32'd0);
        chk("rst_count",     32'(enc_count),   32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single ADD, one cycle latency
        req_add();
        @(negedge clk);
        in_valid = 1'b0;
        $display("tx ADD word=0x%08h count=%0d", instruction_word, enc_count);
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_word",  instruction_word, W_ADD);
        chk("add_count", 32'(enc_count), 32'd1);
        @(negedge clk);
        chk("add_drained", 32'(out_valid), 32'd0);

        // SUB then LUI, consumer stalled, then drained in order
        out_ready = 1'b0;
        req_sub();
        @(negedge clk);
        req_lui();
        @(negedge clk);
        in_valid = 1'b0;
        $display("tx SUB/LUI queued head=0x%08h count=%0d", instruction_word, enc_count);
        chk("ord_head_sub", instruction_word, W_SUB);
        chk("ord_full",     32'(in_ready), 32'd0);
        chk("ord_count",    32'(enc_count), 32'd3);
        out_ready = 1'b1;
        @(negedge clk);
        chk("ord_head_lui", instruction_word, W_LUI);
        chk("ord_valid",    32'(out_valid), 32'd1);
        @(negedge clk);
        chk("ord_empty",    32'(out_valid), 32'd0);

        // STORE and SRAI
        req(3'd3, 4'b0010, 1'b0, 5'd0, 5'd13, 5'd21, 32'h0000_00ED);
        @(negedge clk);
        in_valid = 1'b0;
        $display("tx STORE word=0x%08h", instruction_word);
        chk("store_word", instruction_word, W_STORE);
        req(3'd1, 4'b1101, 1'b1, 5'd1, 5'd2, 5'd0, 32'h0000_0003);
        @(negedge clk);
        in_valid = 1'b0;
        $display("tx SRAI word=0x%08h", instruction_word);
        chk("srai_word",  instruction_word, W_SRAI);
        chk("srai_count", 32'(enc_count), 32'd5);
        @(negedge clk);

        // Back-to-back with a stalled consumer
        out_ready = 1'b0;
        req_add();
        @(negedge clk);
        chk("bb_ready1", 32'(in_ready), 32'd1);
        req_sub();
        @(negedge clk);
        req_lui();
        chk("bb_ready2", 32'(in_ready), 32'd0);
        repeat (2) @(negedge clk);
        $display("tx back-to-back stalled head=0x%08h in_ready=%0d", instruction_word, in_ready);
        chk("bb_head_stable", instruction_word, W_ADD);
        chk("bb_stall_count", 32'(enc_count), 32'd7);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bb_head_after_pop", instruction_word, W_SUB);
        chk("bb_ready_after_pop", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bb_third_count", 32'(enc_count), 32'd8);
        chk("bb_full_again",  32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bb_drain_lui", instruction_word, W_LUI);
        @(negedge clk);
        chk("bb_drain_empty", 32'(out_valid), 32'd0);

        // Illegal LOAD funct3=011
        req_bad();
        @(negedge clk);
        in_valid = 1'b0;
        $display("tx illegal LOAD err=%0d count=%0d", err_illegal, enc_count);
        chk("ill_err",   32'(err_illegal), 32'd1);
        chk("ill_valid", 32'(out_valid),   32'd0);
        chk("ill_count", 32'(enc_count),   32'd8);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("clr_err", 32'(err_illegal), 32'd0);
        err_clr = 1'b1;
        req_bad();
        @(negedge clk);
        err_clr = 1'b0;
        in_valid = 1'b0;
        $display("tx illegal+clr err=%0d", err_illegal);
        chk("clr_set_wins", 32'(err_illegal), 32'd1);
        chk("clr_count",    32'(enc_count),   32'd8);

        // Asynchronous reset with two words queued
        out_ready = 1'b0;
        req_add();
        @(negedge clk);
        req_sub();
        @(negedge clk);
        in_valid = 1'b0;
        chk("arst_pre_full", 32'(in_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        $display("tx async reset out_valid=%0d count=%0d in_ready=%0d", out_valid, enc_count, in_ready);
        chk("arst_valid",    32'(out_valid),   32'd0);
        chk("arst_count",    32'(enc_count),   32'd0);
        chk("arst_in_ready", 32'(in_ready),    32'd1);
        chk("arst_word",     instruction_word, 32'd0);
        chk("arst_err",      32'(err_illegal), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rv_instr_encoder.md
Name: rv_instr_encoder

Overview:
- Encodes decoded control fields back into a 32-bit RV32I instruction word; the inverse of the CONTROL_R decode path.
- Used as an instruction source for the core's stimulus and self-check path: test sequencers issue field-level requests, and this block emits legal instruction words.
- Valid/ready in, valid/ready out, with a small output FIFO, an illegal-combination checker and an encode counter.

Parameters:
- DEPTH, 2, output FIFO entries (power of two, 2..16)
- CNT_W, 16, width of enc_count

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  request can be accepted
- inst_type  in  3  0=R 1=I-ALU 2=LOAD 3=STORE 4=LUI; 5..7 illegal
- alu_ctrl  in  4  [2:0]=funct3, [3]=funct7[5] (SUB/SRA/SRAI)
- shamt_en  in  1  I-ALU shift form
- rd  in  5  destination register
- rs1  in  5  source 1
- rs2  in  5  source 2
- imm  in  32  immediate, raw
- out_valid  out  1  instruction_word valid
- out_ready  in  1  consumer accepts word
- instruction_word  out  32  encoded instruction (FIFO head)
- err_illegal  out  1  sticky illegal-request flag
- err_clr  in  1  synchronous clear of err_illegal
- enc_count  out  CNT_W  legal words encoded since reset

Behaviour:
- Reset values: in_ready=1, out_valid=0, instruction_word=0, err_illegal=0, enc_count=0; FIFO emptied, pointers=0. Reset mid-transfer discards all queued words.
- Request handshake: accepted on a clock edge with in_valid&in_ready. in_ready=(occupancy<DEPTH), registered; no same-cycle pass-through when full.
- Latency: a legal request accepted at edge N appears at the FIFO head (out_valid=1) after edge N if the FIFO was empty. Words leave in request order.
- Output handshake: pop on out_valid&out_ready. instruction_word and out_valid are held stable while out_ready=0. Simultaneous push and pop keeps occupancy unchanged.
- Pointers wrap modulo DEPTH.
- Opcode encoding, by inst_type:
  - R: 0110011; funct7={1'b0,alu_ctrl[3],5'b0}; rs2, rs1, funct3, rd.
  - I-ALU: 0010011; imm[11:0]->[31:20]. With shamt_en, [31:25]={1'b0,alu_ctrl[3],5'b0} and [24:20]=imm[4:0].
  - LOAD: 0000011; imm[11:0]->[31:20].
  - STORE: 0100011; imm[11:5]->[31:25], imm[4:0]->[11:7]; rd ignored.
  - LUI: 0110111; imm[31:12]->[31:12]; rs1, rs2 and funct3 ignored.
- Illegal request conditions:
  - inst_type 5..7.
  - R with alu_ctrl[3]=1 and funct3 not 000/101.
  - I-ALU with shamt_en not equal to (funct3==001 or 101).
  - I-ALU with alu_ctrl[3]=1 unless funct3=101.
  - shamt_en=1 on any non-I-ALU type.
  - LOAD funct3 in {011,110,111}.
  - STORE funct3 > 010.
- Illegal request handling: the handshake completes, nothing is pushed, err_illegal sets on the next edge, enc_count is unchanged.
- err_clr: clears err_illegal. If err_clr and a new illegal acceptance occur in the same cycle, the set wins.
- enc_count: increments per legal push and saturates at all-ones.

Optional Feature:
- Macro: RV_ENC_PARITY_EN.
- When defined: adds output port out_parity (1 bit) = XOR of all 32 bits of the head word. Parity is computed at push, stored alongside the word in the FIFO, and resets to 0.
- When undefined: no port and no storage. All other behaviour is identical.

Test Plan:
- Reset, then R request rd=5 rs1=21 rs2=4 alu_ctrl=0000, out_ready=1 -> instruction_word=0x004A82B3 one cycle after acceptance; enc_count=1.
- R SUB rd=6 rs1=21 rs2=5 alu_ctrl=1000 -> 0x405A8333. LUI rd=13 imm=0x0F56B000 -> 0x0F56B6B7, emitted in order.
- STORE rs1=13 rs2=21 funct3=010 imm=0x0ED -> 0x0F56A6A3.
- out_ready=0, DEPTH=2, three back-to-back requests -> in_ready low after the 2nd acceptance; the head word stays stable; the 3rd request is accepted only after the first pop.
- LOAD alu_ctrl=0011 -> no push, err_illegal=1, enc_count unchanged. Pulse err_clr -> err_illegal=0. err_clr together with a new illegal request -> err_illegal stays 1.
- Assert rst with 2 words queued -> out_valid=0, enc_count=0 and in_ready=1 immediately, without waiting for a clock edge.
